// File: rtl/timer_peripheral_pkg.sv
// Shared constants for the memory-mapped timer peripheral.
// Register word offsets (Address[4:2]) and TCON bit positions.
package timer_peripheral_pkg;

  localparam logic [2:0] OFF_TH   = 3'd0;
  localparam logic [2:0] OFF_TL   = 3'd1;
  localparam logic [2:0] OFF_TCON = 3'd2;
  localparam logic [2:0] OFF_LED  = 3'd3;
  localparam logic [2:0] OFF_SW   = 3'd4;
  localparam logic [2:0] OFF_DIGI = 3'd5;
  localparam logic [2:0] OFF_TICK = 3'd6;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;

  localparam logic [31:0] TL_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/timer_peripheral_core.sv
// Reloadable 32-bit timer: TH/TL/TCON, overflow reload and IRQ level.
// CPU writes take priority over hardware updates of the same register.
module timer_peripheral_core
  import timer_peripheral_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        th_we_i,
  input  logic        tl_we_i,
  input  logic        tcon_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] th_o,
  output logic [31:0] tl_o,
  output logic [2:0]  tcon_o,
  output logic        irq_o
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;

  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    // A TL store suppresses both the count and the overflow side effects
    if (tcon_q[TCON_EN] && !tl_we_i) begin
      if (tl_q == TL_MAX) begin
        tl_d = th_q;
        if (tcon_q[TCON_IE]) tcon_d[TCON_ST] = 1'b1;
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end
    if (th_we_i)   th_d   = wdata_i;
    if (tl_we_i)   tl_d   = wdata_i;
    if (tcon_we_i) tcon_d = wdata_i[2:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th_o   = th_q;
  assign tl_o   = tl_q;
  assign tcon_o = tcon_q;
  assign irq_o  = tcon_q[TCON_IE] & tcon_q[TCON_ST];

endmodule

// File: rtl/timer_peripheral.sv
// Bus-mapped timer, LED/switch/7-segment registers and SYSTICK.
// Decodes a 32-byte window at BASE_ADDR; reads are combinational.
module timer_peripheral
  import timer_peripheral_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          LED_W     = 8,
  parameter int          SW_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Address,
  input  logic [31:0]      WriteData,
  input  logic             MemRd,
  input  logic             MemWr,
  output logic [31:0]      ReadData,
  output logic [LED_W-1:0] led,
  input  logic [SW_W-1:0]  switch,
  output logic [11:0]      digi,
  output logic             IRQ
);

  logic        hit;
  logic [2:0]  off;
  logic        we;
  logic        unused_addr;
  logic [31:0] th, tl;
  logic [2:0]  tcon;

  logic [LED_W-1:0] led_q, led_d;
  logic [11:0]      digi_q, digi_d;
  logic [31:0]      tick_q, tick_d;

  assign hit = (Address[31:5] == BASE_ADDR[31:5]);
  assign off = Address[4:2];
  assign we  = MemWr && hit;
  assign unused_addr = ^Address[1:0];

  timer_peripheral_core u_core (
    .clk       (clk),
    .rst_n     (reset),
    .th_we_i   (we && off == OFF_TH),
    .tl_we_i   (we && off == OFF_TL),
    .tcon_we_i (we && off == OFF_TCON),
    .wdata_i   (WriteData),
    .th_o      (th),
    .tl_o      (tl),
    .tcon_o    (tcon),
    .irq_o     (IRQ)
  );

  always_comb begin
    led_d  = led_q;
    digi_d = digi_q;
    tick_d = tick_q + 32'd1;
    if (we && off == OFF_LED)  led_d  = WriteData[LED_W-1:0];
    if (we && off == OFF_DIGI) digi_d = WriteData[11:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q  <= '0;
      digi_q <= '0;
      tick_q <= '0;
    end else begin
      led_q  <= led_d;
      digi_q <= digi_d;
      tick_q <= tick_d;
    end
  end

  always_comb begin
    ReadData = '0;
    if (MemRd && hit) begin
      unique case (off)
        OFF_TH:   ReadData = th;
        OFF_TL:   ReadData = tl;
        OFF_TCON: ReadData = {29'd0, tcon};
        OFF_LED:  ReadData = {{(32-LED_W){1'b0}}, led_q};
        OFF_SW:   ReadData = {{(32-SW_W){1'b0}}, switch};
        OFF_DIGI: ReadData = {20'd0, digi_q};
        OFF_TICK: ReadData = tick_q;
        default:  ReadData = '0;
      endcase
    end
  end

  assign led  = led_q;
  assign digi = digi_q;

endmodule

// File: tb/tb_timer_peripheral.sv
// Directed bench for timer_peripheral with immediate-assertion checks.
// Hand-computed expectations; one summary line at the end.
module tb_timer_peripheral;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] WriteData = '0;
  logic        MemRd = 1'b0;
  logic        MemWr = 1'b0;
  logic [31:0] ReadData;
  logic [7:0]  led;
  logic [7:0]  switch = 8'h5A;
  logic [11:0] digi;
  logic        IRQ;

  int errors = 0;
  int checks = 0;
  logic [31:0] v, t0;

  timer_peripheral dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .WriteData (WriteData),
    .MemRd     (MemRd),
    .MemWr     (MemWr),
    .ReadData  (ReadData),
    .led       (led),
    .switch    (switch),
    .digi      (digi),
    .IRQ       (IRQ)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    @(negedge clk);
    Address = BASE + off;
    WriteData = d;
    MemWr = 1'b1;
    @(posedge clk);
    #1 MemWr = 1'b0;
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] d);
    Address = BASE + off;
    MemRd = 1'b1;
    #1 d = ReadData;
    MemRd = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    rd(32'h00, v); check("rst_th", v, 32'h0);
    rd(32'h04, v); check("rst_tl", v, 32'h0);
    rd(32'h08, v); check("rst_tcon", v, 32'h0);
    rd(32'h0C, v); check("rst_led", v, 32'h0);
    rd(32'h10, v); check("rst_sw", v, 32'h0000_005A);
    rd(32'h14, v); check("rst_digi", v, 32'h0);
    rd(32'h18, v); check("rst_tick", v, 32'h0);
    check("rst_irq", {31'd0, IRQ}, 32'h0);
    #10 reset = 1'b1;

    // overflow with reload and interrupt
    wr(32'h00, 32'hFFFF_FFF0);
    wr(32'h04, 32'hFFFF_FFFE);
    wr(32'h08, 32'h3);
    rd(32'h04, v); check("tl_start", v, 32'hFFFF_FFFE);
    tick(1);
    rd(32'h04, v); check("tl_max", v, 32'hFFFF_FFFF);
    check("irq_pre", {31'd0, IRQ}, 32'h0);
    tick(1);
    rd(32'h04, v); check("tl_reload", v, 32'hFFFF_FFF0);
    rd(32'h08, v); check("tcon_st", v, 32'h7);
    check("irq_set", {31'd0, IRQ}, 32'h1);

    // clear status, second overflow
    wr(32'h08, 32'h3);
    check("irq_clr", {31'd0, IRQ}, 32'h0);
    rd(32'h08, v); check("tcon_clr", v, 32'h3);
    rd(32'h04, v); check("tl_after_clr", v, 32'hFFFF_FFF1);
    tick(14);
    rd(32'h04, v); check("tl_max2", v, 32'hFFFF_FFFF);
    check("irq_pre2", {31'd0, IRQ}, 32'h0);
    tick(1);
    check("irq_set2", {31'd0, IRQ}, 32'h1);
    rd(32'h04, v); check("tl_reload2", v, 32'hFFFF_FFF0);

    // TL write in the overflow cycle wins
    wr(32'h08, 32'h0);
    wr(32'h04, 32'hFFFF_FFFF);
    wr(32'h08, 32'h3);
    wr(32'h04, 32'h5);
    rd(32'h04, v); check("tl_wr_wins", v, 32'h5);
    rd(32'h08, v); check("tcon_no_st", v, 32'h3);
    check("irq_no_st", {31'd0, IRQ}, 32'h0);
    tick(1);
    rd(32'h04, v); check("tl_inc", v, 32'h6);

    // no IE: reload without status; TH write during overflow
    wr(32'h08, 32'h0);
    wr(32'h04, 32'hFFFF_FFFF);
    wr(32'h08, 32'h1);
    wr(32'h00, 32'h0000_1234);
    rd(32'h04, v); check("tl_old_th", v, 32'hFFFF_FFF0);
    rd(32'h00, v); check("th_new", v, 32'h0000_1234);
    rd(32'h08, v); check("tcon_noie", v, 32'h1);
    check("irq_noie", {31'd0, IRQ}, 32'h0);
    wr(32'h08, 32'h0);
    rd(32'h04, v); check("tl_freeze0", v, 32'hFFFF_FFF1);
    tick(10);
    rd(32'h04, v); check("tl_freeze10", v, 32'hFFFF_FFF1);

    // LED / DIGI / SYSTICK / unmapped
    wr(32'h0C, 32'hFFFF_FFA5);
    wr(32'h14, 32'hFFFF_FABC);
    check("led_out", {24'd0, led}, 32'hA5);
    check("digi_out", {20'd0, digi}, 32'hABC);
    rd(32'h14, v); check("digi_rd", v, 32'hABC);
    rd(32'h18, t0);
    wr(32'h18, 32'hDEAD_0000);
    rd(32'h18, v); check("tick_ro", v, t0 + 32'd1);
    tick(1);
    rd(32'h18, v); check("tick_inc", v, t0 + 32'd2);
    wr(32'h1C, 32'h1234_5678);
    rd(32'h1C, v); check("unmapped_rd", v, 32'h0);
    rd(32'h0C, v); check("led_kept", v, 32'hA5);
    rd(32'h00, v); check("th_kept", v, 32'h0000_1234);
    rd(32'h04, v); check("tl_kept", v, 32'hFFFF_FFF1);
    Address = 32'h5000_0000;
    MemRd = 1'b1;
    #1 check("miss_rd", ReadData, 32'h0);
    Address = BASE + 32'h0C;
    MemRd = 1'b0;
    #1 check("no_rd", ReadData, 32'h0);

    // async reset while interrupting
    wr(32'h08, 32'h7);
    check("irq_forced", {31'd0, IRQ}, 32'h1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_irq", {31'd0, IRQ}, 32'h0);
    check("arst_led", {24'd0, led}, 32'h0);
    check("arst_digi", {20'd0, digi}, 32'h0);
    rd(32'h00, v); check("arst_th", v, 32'h0);
    rd(32'h18, v); check("arst_tick", v, 32'h0);
    #10 reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/timer_peripheral.md
Name: timer_peripheral

Overview:
- Memory-mapped peripheral on the data bus.
- Contains a reloadable 32-bit timer, LED/switch/7-segment registers and a free-running tick counter.
- Drives the IRQ line consumed by the instruction-decode control unit.
- The CPU handles the interrupt, then clears the status bit by a store to TCON. This completes the interrupt handshake from the source side.

Parameters:
- BASE_ADDR, 32'h4000_0000, word-aligned base of the register window.
- LED_W, 8, width of the LED output register.
- SW_W, 8, width of the switch input.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset
- Address  input  32  byte address from the MEM stage
- WriteData  input  32  store data
- MemRd  input  1  load strobe
- MemWr  input  1  store strobe
- ReadData  output  32  load data (combinational)
- led  output  LED_W  LED register
- switch  input  SW_W  board switches
- digi  output  12  7-segment drive register
- IRQ  output  1  interrupt request, level

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0x00 TH: reload value, RW.
  - 0x04 TL: counter, RW.
  - 0x08 TCON: bits [2:0], RW; upper bits read 0.
    - bit0 = count enable
    - bit1 = interrupt enable
    - bit2 = interrupt status
  - 0x0C LED: RW, LED_W bits.
  - 0x10 SWITCH: RO, zero-extended.
  - 0x14 DIGI: RW, 12 bits.
  - 0x18 SYSTICK: RO.
- Decode compares Address[31:5] with BASE_ADDR and uses Address[4:2]. Address[1:0] is ignored.
- Unmapped offsets: reads return 0, writes are dropped.
- Reset (asynchronous, while reset==0): TH, TL, TCON, LED, DIGI and SYSTICK all clear to 0. IRQ is therefore 0.
- Reads: ReadData = selected register when MemRd && hit, else 32'h0. Zero-cycle latency, purely combinational.
- Writes: take effect on the rising clk edge when MemWr && hit. The new value is visible to a read in the next cycle.
- Timer, each cycle with TCON[0]=1 and no write to TL:
  - If TL==32'hFFFF_FFFF: TL<=TH, and TCON[2]<=1 if TCON[1]==1.
  - Otherwise TL<=TL+1 (modulo 2^32, no carry out).
- TCON[0]=0 freezes TL. TH is never modified by hardware.
- IRQ = TCON[1] & TCON[2]. Registered-state derived, no combinational path from bus inputs.
- Simultaneous events:
  - CPU write to TL in the overflow cycle: the write wins; no reload occurs and no status is set.
  - CPU write to TCON in the overflow cycle: the written value wins for all bits, including bit2. Software therefore clears status by writing bit2=0.
  - Write to TH in the overflow cycle: the reload uses the old TH.
- Clearing TCON[1] deasserts IRQ next cycle but leaves TCON[2] set. Re-enabling bit1 re-raises IRQ.
- SYSTICK increments every cycle, wraps at 2^32, and ignores writes.
- Reset mid-count or mid-interrupt returns everything to the reset values immediately. IRQ drops asynchronously.

Decomposition:
- Shared package holds:
  - register offset constants: OFF_TH, OFF_TL, OFF_TCON, OFF_LED, OFF_SW, OFF_DIGI, OFF_TICK
  - TCON bit indices: TCON_EN, TCON_IE, TCON_ST
- One natural sub-module, timer_core: holds TH/TL/TCON, the reload logic and IRQ generation, with write-enable inputs from the decode.
- The top level keeps address decode, the read mux and the LED/DIGI/SYSTICK registers.

Test Plan:
- Reset, then read every offset -> all 0 (SWITCH returns the switch input); IRQ=0.
- Write TH=32'hFFFF_FFF0, TL=32'hFFFF_FFFE, TCON=3'b011:
  - TL reads 32'hFFFF_FFFF after 1 cycle, then 32'hFFFF_FFF0.
  - TCON reads 3'b111 and IRQ=1 from the cycle after reload.
- With IRQ=1, write TCON=3'b011 -> next cycle IRQ=0 and TCON=3'b011. A second overflow 16 cycles later re-raises IRQ.
- TL=32'hFFFF_FFFF, TCON=3'b011; in the overflow cycle write TL=32'h5 -> TL=5, TCON[2]=0, IRQ stays 0.
- TCON=3'b001 with an overflow -> TL reloads, TCON[2]=0, IRQ=0. Then write TCON=3'b000 -> TL stays frozen for 10 cycles.
- Write LED=8'hA5 and DIGI=12'hABC; write 0x18; write to BASE+0x1C:
  - led=8'hA5 and digi=12'hABC.
  - SYSTICK unchanged by its write and increments by 1 per cycle.
  - BASE+0x1C reads 0; no register changed.
  - Assert reset mid-run -> all outputs 0 asynchronously.
